// File: rtl/obi_sram_responder.sv
// Slave end of the core's req/gnt/rvalid bus: word-addressed SRAM with byte enables,
// programmable grant wait states, fixed response latency and a sticky protocol-error flag.
module obi_sram_responder #(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          GNT_WAIT   = 0,
    parameter int          RVALID_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        proto_err_o,
    input  logic        clr_proto_err_i
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
    localparam logic [2:0]  WAIT_LOAD = (GNT_WAIT > 1) ? 3'(GNT_WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // With no wait states the grant is a combinational echo of req, forced low in reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (GNT_WAIT == 0) begin
                    gnt_o = req_i & rst_ni;
                end else if (req_i) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (GNT_WAIT == 1) ? GRANT : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic          txn;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic [31:0]   mem [MEM_WORDS];

    assign txn      = req_i & gnt_o;
    assign in_range = (addr_i >= BASE_ADDR) && ({1'b0, addr_i} < LIMIT);
    // BASE_ADDR is aligned to the memory size, so the offset's index bits are the address's.
    assign word_idx = addr_i[AW+1:2];

    always_ff @(posedge clk_i) begin
        if (txn && we_i && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (be_i[n]) begin
                    mem[word_idx][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    logic [RVALID_LAT-1:0] pipe_valid;
    logic [RVALID_LAT-1:0] pipe_err;
    logic [31:0]           pipe_rdata [RVALID_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < RVALID_LAT; i++) begin
                pipe_rdata[i] <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= txn;
            pipe_err[0]   <= txn & ~in_range;
            pipe_rdata[0] <= (txn && !we_i && in_range) ? mem[word_idx] : 32'h0;
            for (int i = 1; i < RVALID_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    assign rvalid_o = pipe_valid[RVALID_LAT-1];
    assign err_o    = pipe_err[RVALID_LAT-1];
    assign rdata_o  = pipe_rdata[RVALID_LAT-1];

    logic        pending_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic        waiting, mismatch, set_err, proto_q;

    assign waiting  = req_i & ~gnt_o;
    assign mismatch = (addr_i != addr_q) | (we_i != we_q) | (be_i != be_q) | (wdata_i != wdata_q);
    assign set_err  = (pending_q & (~req_i | mismatch)) | ((state_q == GRANT) & ~req_i);

    // The request snapshot is taken in the first waiting cycle and held until grant or abandon.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            proto_q   <= 1'b0;
        end else begin
            pending_q <= waiting;
            if (waiting && !pending_q) begin
                we_q    <= we_i;
                be_q    <= be_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (set_err) begin
                proto_q <= 1'b1;
            end else if (clr_proto_err_i) begin
                proto_q <= 1'b0;
            end
        end
    end

    assign proto_err_o = proto_q;

endmodule

// File: doc/obi_sram_responder.md
# obi_sram_responder

Memory-side responder for the core's req/gnt/rvalid instruction/data bus: the slave end that a `riscv_core` (or a lockstepped core group) issues requests into. It accepts requests with programmable grant wait states, performs byte-enabled reads and writes on an internal word-addressed SRAM, and returns in-order responses with programmable latency. Out-of-range accesses get an error response, and initiator-side protocol violations are flagged sticky for the fault-handling logic.

## Interface
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words; power of two, 16..65536.
- `BASE_ADDR`, 32'h0000_0000: byte base address; aligned to `4*MEM_WORDS`.
- `GNT_WAIT`, 0: wait cycles from request to grant, 0..7.
- `RVALID_LAT`, 1: cycles from grant to rvalid, 1..4.

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `req_i` in 1: request valid.
- `gnt_o` out 1: request accepted this cycle.
- `we_i` in 1: 1 = write, 0 = read.
- `be_i` in 4: byte enables; bit n covers `wdata_i[8n+7:8n]`.
- `addr_i` in 32: byte address; bits [1:0] are ignored.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid, one cycle per granted request.
- `rdata_o` out 32: read data; 0 for writes and errors.
- `err_o` out 1: error response, qualified by `rvalid_o`.
- `proto_err_o` out 1: sticky protocol-violation flag.
- `clr_proto_err_i` in 1: synchronous clear of `proto_err_o`.

## Operation
- In range: `addr_i >= BASE_ADDR` and `addr_i < BASE_ADDR + 4*MEM_WORDS`. Word index = `(addr_i - BASE_ADDR) >> 2`, truncated to log2(MEM_WORDS) bits.
- Grant FSM:
  - IDLE: if `GNT_WAIT`=0, `gnt_o = req_i` combinationally. Otherwise `req_i` loads the wait counter with `GNT_WAIT-1` and moves to WAIT; `gnt_o`=0.
  - WAIT: the counter decrements each cycle. At 0, go to GRANT.
  - GRANT: `gnt_o` = 1 for exactly one cycle. It is not gated by `req_i`; if `req_i` is low here, `proto_err_o` sets and no transaction is recorded. Then return to IDLE.
- Grant cycle = a cycle where `req_i && gnt_o`:
  - Write, in range: each byte with `be_i[n]`=1 is written at the closing clock edge; bytes with `be_i[n]`=0 are unchanged. `be_i`=0 is a legal no-op write.
  - Read, in range: captures the word as it stands before that edge.
  - Out of range: memory is untouched; the response carries `err_o`=1 and `rdata_o`=0.
- Response pipeline: `RVALID_LAT` stages, each holding {valid, err, rdata}, advancing every cycle. No backpressure. Responses leave in grant order.
- Protocol checks, active from the first cycle of an ungranted request (`req_i`=1, `gnt_o`=0) until its grant. `proto_err_o` sets if any of these occur:
  - `req_i` falls before the grant;
  - `addr_i`, `we_i`, `be_i` or `wdata_i` changes while waiting. This is checked against a copy registered in the first waiting cycle.
- `proto_err_o` stays set until `clr_proto_err_i`. If a set condition and the clear occur in the same cycle, set wins.

## Timing
- Reset (asynchronous, while `rst_ni`=0):
  - `gnt_o`=0 (the combinational path is forced low too), `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `proto_err_o`=0.
  - FSM returns to IDLE and all pipeline stages are cleared.
  - SRAM contents are not reset.
  - Responses in flight are dropped and no rvalid is produced for them. A write whose grant edge coincides with reset assertion is undefined.
- Grant timing: request first seen in cycle t (FSM in IDLE) is granted in cycle t+`GNT_WAIT`.
- Throughput: with `GNT_WAIT`=0, one grant per cycle. With `GNT_WAIT`=N>0, consecutive grants are at least N+1 cycles apart.
- Response timing: `rvalid_o` is high in cycle g+`RVALID_LAT` for a grant in cycle g.
- Read-after-write: a read granted in cycle g+1 sees the write granted in cycle g. A read in the same cycle as a write is impossible on a single port.
- Maximum outstanding responses = `RVALID_LAT`. No counter saturation is possible.

## Test plan
- Defaults: write 32'hDEAD_BEEF at addr 0x10 with `be`=4'hF, then read 0x10. Required: grants in the same cycles as the requests, `rvalid_o` exactly 1 cycle after each grant, read data 32'hDEAD_BEEF, `err_o`=0.
- Byte enables: write 32'h1122_3344 with `be`=4'b0101 over a word holding 32'hFFFF_FFFF, then read it back. Required: read data 32'hFF22_FF44.
- `GNT_WAIT`=3, `RVALID_LAT`=4: back-to-back reads with `req_i` held. Required: `gnt_o` at t+3 and t+7, `rvalid_o` at t+7 and t+11, in order.
- Out of range: read at `BASE_ADDR+4*MEM_WORDS`, and a write there. Required: `rvalid_o`=1 with `err_o`=1 and `rdata_o`=0; the following in-range read shows memory unchanged.
- Protocol violation: with `GNT_WAIT`=2, change `addr_i` one cycle after raising `req_i`. Required: `proto_err_o`=1 the next cycle; it stays 1 until `clr_proto_err_i`, and clears one cycle after that.
- Reset mid-flight: with `RVALID_LAT`=3, assert `rst_ni`=0 one cycle after a grant. Required: no `rvalid_o` for that grant, all outputs 0 during reset, and a normal grant on the first request after release.
